ghost_painter: RTL and testbench
================================

# ghost_painter

Write-side controller for the ghost-piece bitmap RAM in the Tetris video path. On each request it erases the four cells of the previously drawn ghost and paints the four cells of the new landing position. On request it also sweeps the whole RAM to transparent. Its registered write port drives the bitmap RAM's `we`/`addr_w`/`din`; the RAM's read side stays with the pixel renderer.

## Interface
- `COORD_W`, 5: bits per cell coordinate.
- `ADDR_WIDTH`, 10: RAM address width; must equal 2*COORD_W.
- `DATA_WIDTH`, 2: color code width.
- `BOARD_W`, 10: playfield columns; x ≥ BOARD_W is off-board.
- `BOARD_H`, 20: playfield rows; y ≥ BOARD_H is off-board.
- `GHOST_COLOR`, 2'b01: code written for ghost cells; 2'b00 means transparent.
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: paint request, sampled only in IDLE.
- `clear_req` in 1: full-RAM clear request, sampled only in IDLE.
- `cell_x` in 4*COORD_W: packed x of cells 0..3; cell i is bits [i*COORD_W +: COORD_W].
- `cell_y` in 4*COORD_W: packed y of cells 0..3, same layout.
- `we` out 1: RAM write enable, registered.
- `addr_w` out ADDR_WIDTH: RAM write address, registered; equals {y, x}.
- `din` out DATA_WIDTH: RAM write data, registered.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle completion pulse.

## Operation
- States and transitions:
  - IDLE → CLEAR when `clear_req`.
  - IDLE → ERASE when `start`.
  - ERASE (4 cycles) → PAINT (4 cycles) → DONE (1 cycle) → IDLE.
  - CLEAR (2**ADDR_WIDTH cycles) → DONE.
- Simultaneous `start` and `clear_req` in IDLE: clear wins and `start` is dropped. Requests outside IDLE, including DONE, are ignored and not queued.
- On accepting `start`:
  - Latch `cell_x`/`cell_y` into the new-cell registers.
  - The previous new-cell set, with its valid bits, becomes the old-cell set.
- ERASE, cycle i: write 2'b00 to old cell i if old valid[i] is set; otherwise hold `we` at 0.
- PAINT, cycle i: write GHOST_COLOR to new cell i if it is on-board; otherwise hold `we` at 0. Store valid[i] = on-board.
- Off-board cells still consume their cycle, so latency is fixed.
- Overlap between the old and new sets: erase precedes paint, so the overlapping cell ends as GHOST_COLOR.
- Duplicate cells in one set are written twice; this is harmless.
- CLEAR:
  - `addr_w` counts 0..2**ADDR_WIDTH-1 with `din`=0 and `we`=1 every cycle; the counter wraps to 0 on exit.
  - All stored valid bits are cleared.
- Reset state: IDLE, all valid bits 0, `we`/`addr_w`/`din`/`done` = 0, `busy` = 0, except as modified under Configuration.
- Reset mid-operation: the next edge returns the block to IDLE with `we`=0. Partial writes remain in the RAM, and the old-cell set is forgotten.

## Timing
- `start` sampled at edge k → `we`/`addr_w`/`din` valid during cycles k+1..k+8 (erase 0..3, then paint 0..3).
- `done` is high in cycle k+9 only; `busy` is high in cycles k+1..k+9.
- The earliest next `start` is accepted at edge k+10.
- `clear_req` at edge k → writes in cycles k+1..k+1024, `done` at k+1025.
- Inputs are needed only at the accepting edge; they may change afterwards.

## Configuration
- `GHOST_CLEAR_ON_RESET_EN` defined:
  - On leaving reset the FSM enters CLEAR instead of IDLE.
  - `busy` reads 1 in the first cycle after `reset_n` rises.
  - The RAM is swept; `done` pulses at the end of the sweep.
- Undefined: the block enters IDLE and RAM contents are whatever the initialization file loaded. Upstream issues `clear_req` if needed.

## Structure
- Shared package `ghost_pkg` holds:
  - the state enum (IDLE, ERASE, PAINT, CLEAR, DONE);
  - `coord_t` (COORD_W-bit logic);
  - constants COLOR_CLEAR=2'b00 and CELLS=4.
- No sub-module: one FSM, one 2-bit cell index, one ADDR_WIDTH-bit sweep counter, and old/new cell registers in a single module.

## Test plan
- Reset, no macro, then `start` with cells (3,18),(4,18),(5,18),(4,19):
  - four erase cycles with `we`=0;
  - then writes of 01 to 0x243, 0x244, 0x245, 0x264;
  - `done` at k+9.
- Second `start` with (3,17),(4,17),(5,17),(4,18):
  - erases 0x243, 0x244, 0x245, 0x264;
  - paints 0x223, 0x224, 0x225, 0x244;
  - 0x244 ends as 01 in a RAM model.
- Cell at x=12, y=19 (off-board): its paint cycle has `we`=0; in the next request its erase cycle also has `we`=0.
- `start` and `clear_req` in the same cycle: 1024 writes of 0 over addresses 0..1023, `done` at k+1025, no paint; the following `start` erases nothing.
- `start` pulsed during PAINT and during DONE: ignored; exactly one `done` observed.
- `reset_n` low during PAINT cycle 2: next cycle `we`=0 and `busy`=0; with `GHOST_CLEAR_ON_RESET_EN`, a full sweep follows and `done` pulses at its end.

Source files
------------

// File: rtl/ghost_pkg.sv
`timescale 1ns/1ps
// ghost_pkg: shared types and constants for the ghost-piece bitmap painter.
package ghost_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERASE = 3'd1,
    PAINT = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Cell coordinate width of the default configuration.
  localparam int COORD_BITS = 5;
  typedef logic [COORD_BITS-1:0] coord_t;

  // Transparent color code and number of cells in a tetromino.
  localparam logic [1:0] COLOR_CLEAR = 2'b00;
  localparam int         CELLS       = 4;

endpackage : ghost_pkg

// File: rtl/ghost_painter.sv
`timescale 1ns/1ps
// ghost_painter: write-side controller for the ghost-piece bitmap RAM.
// Each start erases the previously painted four cells and paints the new
// four; clear_req sweeps the whole RAM to transparent.
// Optional macro GHOST_CLEAR_ON_RESET_EN: leave reset straight into a sweep.
module ghost_painter
  import ghost_pkg::*;
#(
  parameter int                    COORD_W     = 5,
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    DATA_WIDTH  = 2,
  parameter int                    BOARD_W     = 10,
  parameter int                    BOARD_H     = 20,
  parameter logic [DATA_WIDTH-1:0] GHOST_COLOR = 2'b01
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    clear_req,
  input  logic [4*COORD_W-1:0]    cell_x,
  input  logic [4*COORD_W-1:0]    cell_y,
  output logic                    we,
  output logic [ADDR_WIDTH-1:0]   addr_w,
  output logic [DATA_WIDTH-1:0]   din,
  output logic                    busy,
  output logic                    done
);

  if (ADDR_WIDTH != 2 * COORD_W) begin : g_bad_cfg
    $error("ghost_painter: ADDR_WIDTH must equal 2*COORD_W");
  end

  localparam logic [DATA_WIDTH-1:0] WR_CLEAR = DATA_WIDTH'(COLOR_CLEAR);

  state_e                  state_q, state_d;
  logic [1:0]              idx_q, idx_d, idx_nx;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic [4*COORD_W-1:0]    new_x_q, new_x_d, new_y_q, new_y_d;
  logic [4*COORD_W-1:0]    old_x_q, old_x_d, old_y_q, old_y_d;
  logic [CELLS-1:0]        new_v_q, new_v_d, old_v_q, old_v_d;
  logic                    we_q, we_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;

  // RAM address of cell i in a packed set: {y, x}.
  function automatic logic [ADDR_WIDTH-1:0] cell_addr(
    input logic [4*COORD_W-1:0] xs,
    input logic [4*COORD_W-1:0] ys,
    input logic [1:0]           i
  );
    return {ys[int'(i)*COORD_W +: COORD_W], xs[int'(i)*COORD_W +: COORD_W]};
  endfunction

  // Cell i of a packed set lies inside the playfield.
  function automatic logic on_board(
    input logic [4*COORD_W-1:0] xs,
    input logic [4*COORD_W-1:0] ys,
    input logic [1:0]           i
  );
    return (int'(xs[int'(i)*COORD_W +: COORD_W]) < BOARD_W) &&
           (int'(ys[int'(i)*COORD_W +: COORD_W]) < BOARD_H);
  endfunction

  assign idx_nx = idx_q + 2'd1;

  // Next state, cell bookkeeping and the next cycle's RAM write.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    sweep_d = sweep_q;
    new_x_d = new_x_q;
    new_y_d = new_y_q;
    new_v_d = new_v_q;
    old_x_d = old_x_q;
    old_y_d = old_y_q;
    old_v_d = old_v_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          sweep_d = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          din_d   = WR_CLEAR;
          new_v_d = '0;
          old_v_d = '0;
        end else if (start) begin
          state_d = ERASE;
          idx_d   = 2'd0;
          // The previously painted set becomes the one to erase.
          old_x_d = new_x_q;
          old_y_d = new_y_q;
          old_v_d = new_v_q;
          new_x_d = cell_x;
          new_y_d = cell_y;
          new_v_d = '0;
          we_d    = new_v_q[0];
          addr_d  = cell_addr(new_x_q, new_y_q, 2'd0);
          din_d   = WR_CLEAR;
        end
      end

      ERASE: begin
        if (idx_q == 2'd3) begin
          state_d    = PAINT;
          idx_d      = 2'd0;
          we_d       = on_board(new_x_q, new_y_q, 2'd0);
          new_v_d[0] = we_d;
          addr_d     = cell_addr(new_x_q, new_y_q, 2'd0);
          din_d      = GHOST_COLOR;
        end else begin
          idx_d  = idx_nx;
          we_d   = old_v_q[idx_nx];
          addr_d = cell_addr(old_x_q, old_y_q, idx_nx);
          din_d  = WR_CLEAR;
        end
      end

      PAINT: begin
        if (idx_q == 2'd3) begin
          state_d = DONE;
          idx_d   = 2'd0;
          done_d  = 1'b1;
        end else begin
          idx_d           = idx_nx;
          we_d            = on_board(new_x_q, new_y_q, idx_nx);
          new_v_d[idx_nx] = we_d;
          addr_d          = cell_addr(new_x_q, new_y_q, idx_nx);
          din_d           = GHOST_COLOR;
        end
      end

      CLEAR: begin
        if (sweep_q == '1) begin
          state_d = DONE;
          sweep_d = '0;
          done_d  = 1'b1;
        end else begin
          sweep_d = sweep_q + ADDR_WIDTH'(1);
          we_d    = 1'b1;
          addr_d  = sweep_d;
          din_d   = WR_CLEAR;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
`ifdef GHOST_CLEAR_ON_RESET_EN
      state_q <= CLEAR;
      we_q    <= 1'b1;
`else
      state_q <= IDLE;
      we_q    <= 1'b0;
`endif
      idx_q   <= '0;
      sweep_q <= '0;
      new_x_q <= '0;
      new_y_q <= '0;
      new_v_q <= '0;
      old_x_q <= '0;
      old_y_q <= '0;
      old_v_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      sweep_q <= sweep_d;
      new_x_q <= new_x_d;
      new_y_q <= new_y_d;
      new_v_q <= new_v_d;
      old_x_q <= old_x_d;
      old_y_q <= old_y_d;
      old_v_q <= old_v_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
    end
  end

  assign we     = we_q;
  assign addr_w = addr_q;
  assign din    = din_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

endmodule : ghost_painter

// File: tb/tb_ghost_painter.sv
`timescale 1ns/1ps
// tb_ghost_painter: randomized self-checking bench for ghost_painter
// (default build) against a cell-set / RAM reference model.
module tb_ghost_painter;

  localparam int CW = 5;
  localparam int AW = 10;
  localparam int DW = 2;
  localparam int RAM_N = 1 << AW;

  typedef struct {
    bit              we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   din;
  } wr_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic            clear_req = 1'b0;
  logic [4*CW-1:0] cell_x = '0;
  logic [4*CW-1:0] cell_y = '0;
  logic            we;
  logic [AW-1:0]   addr_w;
  logic [DW-1:0]   din;
  logic            busy;
  logic            done;
  logic            ram_init = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  // RAM as written by the DUT, and the RAM the model expects.
  logic [DW-1:0] dut_ram [RAM_N];
  logic [DW-1:0] ref_ram [RAM_N];

  // Model: last painted set and which of its cells were on-board.
  logic [CW-1:0] m_x [4];
  logic [CW-1:0] m_y [4];
  bit            m_v [4];
  wr_t           exp_q [$];

  ghost_painter #(
    .COORD_W(CW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BOARD_W(10), .BOARD_H(20), .GHOST_COLOR(2'b01)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear_req(clear_req),
    .cell_x(cell_x), .cell_y(cell_y), .we(we), .addr_w(addr_w),
    .din(din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < RAM_N; i++) dut_ram[i] <= '0;
    end else if (we === 1'b1) begin
      dut_ram[addr_w] <= din;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*CW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [CW-1:0] pa, pb, pc, pd;
    pa = CW'(a); pb = CW'(b); pc = CW'(c); pd = CW'(d);
    return {pd, pc, pb, pa};
  endfunction

  function automatic int rand_coord(input int lim);
    if ($urandom_range(0, 5) == 0) return int'($urandom_range(lim, 31));
    return int'($urandom_range(0, lim - 1));
  endfunction

  // Model of one paint request: 4 erases of the old set, then 4 paints.
  task automatic model_start(input logic [4*CW-1:0] xs, input logic [4*CW-1:0] ys);
    wr_t e;
    for (int i = 0; i < 4; i++) begin
      e.we = m_v[i]; e.addr = {m_y[i], m_x[i]}; e.din = 2'b00;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 4; i++) begin
      m_x[i] = xs[i*CW +: CW];
      m_y[i] = ys[i*CW +: CW];
      m_v[i] = (int'(m_x[i]) < 10) && (int'(m_y[i]) < 20);
      e.we = m_v[i]; e.addr = {m_y[i], m_x[i]}; e.din = 2'b01;
      exp_q.push_back(e);
    end
  endtask

  task automatic ram_check(input string tag);
    int bad = 0;
    for (int i = 0; i < RAM_N; i++) if (dut_ram[i] !== ref_ram[i]) bad++;
    check(tag, bad, 0);
  endtask

  // Issue one start; optionally poke start during PAINT/DONE, or reset at cycle rst_at.
  task automatic run_start(input logic [4*CW-1:0] xs, input logic [4*CW-1:0] ys,
                           input bit poke, input int rst_at);
    wr_t e;
    @(negedge clk);
    start = 1'b1; cell_x = xs; cell_y = ys;
    model_start(xs, ys);
    @(posedge clk);
    #1;
    start = 1'b0; cell_x = $urandom; cell_y = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = (poke && c == 6);
      e = exp_q.pop_front();
      check($sformatf("we_c%0d", c), we, e.we);
      if (e.we) begin
        check($sformatf("addr_c%0d", c), addr_w, e.addr);
        check($sformatf("din_c%0d", c), din, e.din);
        ref_ram[e.addr] = e.din;
      end
      check($sformatf("busy_c%0d", c), busy, 1);
      if (c == rst_at) begin
        reset_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
        @(negedge clk);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        return;
      end
    end
    @(negedge clk);
    start = poke;
    check("done_hi", done, 1);
    check("busy_done", busy, 1);
    @(negedge clk);
    start = 1'b0;
    check("done_lo", done, 0);
    check("busy_lo", busy, 0);
  endtask

  // Issue a clear (optionally together with start) and check the full sweep.
  task automatic run_clear(input bit with_start);
    int bad = 0;
    @(negedge clk);
    clear_req = 1'b1; start = with_start;
    cell_x = $urandom; cell_y = $urandom;
    @(posedge clk);
    #1;
    clear_req = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    for (int i = 0; i < RAM_N; i++) ref_ram[i] = '0;
    for (int i = 0; i < RAM_N; i++) begin
      @(negedge clk);
      if (we !== 1'b1 || addr_w !== AW'(i) || din !== 2'b00 || done !== 1'b0) bad++;
    end
    check("clear_sweep_errs", bad, 0);
    @(negedge clk);
    check("clear_done_hi", done, 1);
    check("clear_we_off", we, 0);
    @(negedge clk);
    check("clear_done_lo", done, 0);
    check("clear_busy_lo", busy, 0);
  endtask

  initial begin
    int n_done, n_we;
    for (int i = 0; i < RAM_N; i++) ref_ram[i] = '0;
    for (int i = 0; i < 4; i++) begin m_x[i] = '0; m_y[i] = '0; m_v[i] = 1'b0; end

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we0", we, 0);
    check("rst_addr0", addr_w, 0);
    check("rst_din0", din, 0);
    check("rst_done0", done, 0);
    check("rst_busy0", busy, 0);
    ram_init = 1'b0;
    reset_n  = 1'b1;

    // Directed: first ghost, then a shift down by one row (overlap at 0x244).
    run_start(pack4(3, 4, 5, 4), pack4(18, 18, 18, 19), 1'b0, 0);
    run_start(pack4(3, 4, 5, 4), pack4(17, 17, 17, 18), 1'b0, 0);
    check("ram_0x244", dut_ram[10'h244], 2'b01);
    check("ram_0x264", dut_ram[10'h264], 2'b00);
    check("ram_0x223", dut_ram[10'h223], 2'b01);
    ram_check("ram_after_shift");

    // Off-board cell: no paint write now, no erase write next time.
    run_start(pack4(12, 0, 1, 2), pack4(19, 0, 0, 0), 1'b0, 0);
    run_start(pack4(6, 7, 8, 9), pack4(5, 5, 5, 5), 1'b0, 0);

    // start and clear_req together: clear wins; next start erases nothing.
    run_clear(1'b1);
    run_start(pack4(0, 1, 2, 3), pack4(0, 0, 0, 0), 1'b0, 0);
    ram_check("ram_after_clear");

    // Requests during PAINT and DONE are dropped.
    run_start(pack4(4, 4, 4, 4), pack4(10, 11, 12, 13), 1'b1, 0);
    n_done = 0; n_we = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (we === 1'b1) n_we++;
    end
    check("ignored_done_cnt", n_done, 0);
    check("ignored_we_cnt", n_we, 0);

    // Randomized requests with one clear in the middle.
    for (int r = 0; r < 24; r++) begin
      if (r == 12) run_clear(1'b0);
      run_start(pack4(rand_coord(10), rand_coord(10), rand_coord(10), rand_coord(10)),
                pack4(rand_coord(20), rand_coord(20), rand_coord(20), rand_coord(20)),
                1'b0, 0);
    end
    ram_check("ram_after_random");

    // Reset during PAINT cycle 2; old set forgotten afterwards.
    run_start(pack4(1, 2, 3, 4), pack4(7, 7, 7, 7), 1'b0, 7);
    run_start(pack4(5, 6, 7, 8), pack4(9, 9, 9, 9), 1'b0, 0);
    ram_check("ram_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ghost_painter
